// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the core's memory-side blocks
package riscv_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACK_CPU, ARB_ACK_DBG} arb_state_t;
  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between CPU and debug ports with two-cycle grant/ack transactions
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [STARVE_CNT_W-1:0] smax = STARVE_CNT_W'(STARVE_MAX);
  arb_state_t state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic idle, cpu_win, dbg_win;
  // grant decision, next state, starvation counter and memory drive
  always_comb begin
    idle      = state_q == ARB_IDLE;
    cpu_win   = idle & cpu_req & ~(dbg_req & (starve_q == smax));
    dbg_win   = idle & dbg_req & ~cpu_win;
    state_d   = cpu_win ? ARB_ACK_CPU : dbg_win ? ARB_ACK_DBG : ARB_IDLE;
    starve_d  = !idle ? starve_q : (dbg_win | ~dbg_req) ? '0 :
                (starve_q == smax) ? starve_q : starve_q + 1'b1;
    rdata_d   = idle ? mem_rdata : rdata_q;
    mem_we    = ((cpu_win & cpu_we) | (dbg_win & dbg_we)) & ~rst;
    mem_addr  = cpu_win ? cpu_addr : dbg_win ? dbg_addr : '0;
    mem_wdata = cpu_win ? cpu_wdata : dbg_win ? dbg_wdata : '0;
    cpu_ack   = state_q == ARB_ACK_CPU;
    dbg_ack   = state_q == ARB_ACK_DBG;
    cpu_rdata = cpu_ack ? rdata_q : '0;
    dbg_rdata = dbg_ack ? rdata_q : '0;
    cpu_stall = cpu_req & ~cpu_ack;
  end
  // state, counter and captured read data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of the data-memory arbiter against a small word memory
module tb_dmem_arbiter;
  logic clk = 0;
  logic rst, cpu_req, cpu_we, dbg_req, dbg_we, cpu_ack, cpu_stall, dbg_ack, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic preload;
  logic [31:0] mem [0:63];
  int n_cmp = 0, n_bad = 0, cur = 0;

  localparam logic [31:0] D = 32'hDEADBEEF, P = 32'h12345678, C = 32'hCAFEF00D, A = 32'hA5A5A5A5;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 8) ? P : 32'h0;
    end else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  typedef struct {
    logic rst, cr, cw;
    logic [31:0] ca, cd;
    logic dr;
    logic [31:0] da;
    logic ewe, eca, eda, est;
    logic [31:0] ema, ewd, ecr, edr;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t v(input logic r, cr, cw, input logic [31:0] ca, cd, input logic dr,
                             input logic [31:0] da, input logic ewe, eca, eda, est,
                             input logic [31:0] ema, ewd, ecr, edr);
    v = '{r, cr, cw, ca, cd, dr, da, ewe, eca, eda, est, ema, ewd, ecr, edr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, cur, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = v(1,1,1,32'h10,D,1,32'h20, 0,0,0,1,32'h10,D,0,0);
    tbl[1]  = tbl[0];
    tbl[2]  = v(0,1,1,32'h10,D,1,32'h20, 1,0,0,1,32'h10,D,0,0);
    tbl[3]  = v(0,1,1,32'h10,D,1,32'h20, 0,1,0,0,0,0,0,0);
    tbl[4]  = v(0,1,0,32'h10,0,1,32'h20, 0,0,0,1,32'h10,0,0,0);
    tbl[5]  = v(0,1,0,32'h10,0,1,32'h20, 0,1,0,0,0,0,D,0);
    tbl[6]  = tbl[4];
    tbl[7]  = tbl[5];
    tbl[8]  = v(0,1,0,32'h10,0,1,32'h20, 0,0,0,1,32'h20,0,0,0);
    tbl[9]  = v(0,1,0,32'h10,0,1,32'h20, 0,0,1,1,0,0,0,P);
    tbl[10] = tbl[4]; tbl[11] = tbl[5];
    tbl[12] = tbl[4]; tbl[13] = tbl[5];
    tbl[14] = tbl[4]; tbl[15] = tbl[5];
    tbl[16] = tbl[8]; tbl[17] = tbl[9];
    tbl[18] = v(0,0,0,0,0,1,32'h20, 0,0,0,0,32'h20,0,0,0);
    tbl[19] = v(0,1,0,32'h10,0,1,32'h20, 0,0,1,1,0,0,0,P);
    tbl[20] = v(0,1,0,32'h10,0,0,0, 0,0,0,1,32'h10,0,0,0);
    tbl[21] = v(0,1,0,32'h10,0,0,0, 0,1,0,0,0,0,D,0);
    tbl[22] = v(0,1,0,32'h30,0,1,32'h20, 0,0,0,1,32'h30,0,0,0);
    tbl[23] = v(0,1,0,32'h30,0,1,32'h20, 0,1,0,0,0,0,0,0);
    tbl[24] = v(1,1,1,32'h10,C,1,32'h20, 0,0,0,1,32'h10,C,0,0);
    tbl[25] = v(0,1,0,32'h30,0,1,32'h20, 0,0,0,1,32'h30,0,0,0);
    tbl[26] = v(0,1,0,32'h30,0,1,32'h20, 0,1,0,0,0,0,0,0);
    tbl[27] = v(0,1,0,32'h10,0,0,0, 0,0,0,1,32'h10,0,0,0);
    tbl[28] = v(1,1,0,32'h10,0,0,0, 0,1,0,0,0,0,D,0);
    tbl[29] = v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

    preload = 1; rst = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    step();
    preload = 0;

    for (int i = 0; i < 30; i++) begin
      cur = i;
      rst = tbl[i].rst;
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      dbg_req = tbl[i].dr; dbg_we = 0; dbg_addr = tbl[i].da; dbg_wdata = 0;
      #1;
      chk("mem_we", 32'(mem_we), 32'(tbl[i].ewe));
      chk("mem_addr", mem_addr, tbl[i].ema);
      chk("mem_wdata", mem_wdata, tbl[i].ewd);
      chk("cpu_ack", 32'(cpu_ack), 32'(tbl[i].eca));
      chk("dbg_ack", 32'(dbg_ack), 32'(tbl[i].eda));
      chk("cpu_stall", 32'(cpu_stall), 32'(tbl[i].est));
      chk("cpu_rdata", cpu_rdata, tbl[i].ecr);
      chk("dbg_rdata", dbg_rdata, tbl[i].edr);
      step();
      if (i == 26) chk("starve_after_rst", 32'(dut.starve_q), 32'd1);
      if (i == 28) chk("rdata_q_after_rst", dut.rdata_q, 32'h0);
    end

    cur = 100;
    chk("word_after_rst_write", mem[4], D);

    cur = 101;
    rst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h24; dbg_wdata = A;
    #1;
    chk("dbg_wr_we", 32'(mem_we), 32'd1);
    chk("dbg_wr_addr", mem_addr, 32'h24);
    chk("dbg_wr_data", mem_wdata, A);
    step();
    chk("dbg_wr_ack", 32'(dbg_ack), 32'd1);
    chk("dbg_wr_mem", mem[9], A);
    chk("dbg_wr_ack_we", 32'(mem_we), 32'd0);
    dbg_req = 0; dbg_we = 0;
    step();

    cur = 102;
    cpu_req = 1; cpu_addr = 32'h20;
    #1;
    chk("drop_grant_stall", 32'(cpu_stall), 32'd1);
    step();
    cpu_req = 0;
    #1;
    chk("drop_ack", 32'(cpu_ack), 32'd1);
    chk("drop_rdata", cpu_rdata, P);
    chk("drop_stall", 32'(cpu_stall), 32'd0);
    step();
    chk("drop_idle_ack", 32'(cpu_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
